// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: single-edge 32x32 multiply, restoring divide at DIV_BITS quotient bits per edge.
// Latency from the accept edge to Done: MUL 2 edges, divide-by-zero/overflow 2, normal divide DIV_ITERS+2.
// Backpressure: Stall holds IF/ID/ID-EX from the accept cycle until Done; Start while busy is ignored.
module ex_muldiv_unit #(
    parameter int DIV_BITS = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Flush,
    input  logic [2:0]  func3,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic [4:0]  WriteAddress,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [4:0]  Out_WriteAddress
);

    localparam int DIV_ITERS = 32 / DIV_BITS;
    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [1:0]  op_sel;
    logic [4:0]  op_rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [5:0]  cnt;
    logic        dv_zero;
    logic        dv_ovf;

    logic        can_accept;
    logic        accept;
    logic        in_signed;
    logic        in_zero;
    logic        in_ovf;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    state_t      accept_state;

    assign can_accept   = (state == S_IDLE) || (state == S_DONE);
    assign accept       = Start && can_accept && !Flush;
    assign in_signed    = !func3[0];
    assign in_zero      = (Operand2 == 32'h0);
    assign in_ovf       = in_signed && (Operand1 == 32'h80000000) && (Operand2 == 32'hFFFFFFFF);
    assign in_dividend  = (in_signed && Operand1[31]) ? -Operand1 : Operand1;
    assign in_divisor   = (in_signed && Operand2[31]) ? -Operand2 : Operand2;
    assign accept_state = !func3[2] ? S_MUL : ((in_zero || in_ovf) ? S_FIX : S_DIV);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        Stall     = 1'b0;
        if (Flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (Start) state_nxt = accept_state;
                S_MUL:   state_nxt = S_DONE;
                S_DIV:   if (cnt == LAST_ITER) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                S_DONE:  state_nxt = Start ? accept_state : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
        Busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
        Done  = (state == S_DONE);
        Stall = Busy || (Start && can_accept);
    end

    // Extending to 64 bits per func3 makes the truncated 64-bit product
    // equal to the exact signed/unsigned 33x33 product.
    logic        mul_a_sx;
    logic        mul_b_sx;
    logic [63:0] mul_a64;
    logic [63:0] mul_b64;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign mul_a_sx = (op_sel != 2'b11);
    assign mul_b_sx = (op_sel == 2'b01);
    assign mul_a64  = {{32{mul_a_sx && op_a[31]}}, op_a};
    assign mul_b64  = {{32{mul_b_sx && op_b[31]}}, op_b};
    assign prod     = mul_a64 * mul_b64;
    assign mul_res  = (op_sel == 2'b00) ? prod[31:0] : prod[63:32];

    logic [31:0] r_t;
    logic [31:0] q_t;
    logic [32:0] r_sh;

    always_comb begin
        r_t  = rem;
        q_t  = quo;
        r_sh = 33'h0;
        for (int i = 0; i < DIV_BITS; i++) begin
            r_sh = {r_t, q_t[31]};
            q_t  = {q_t[30:0], 1'b0};
            if (r_sh >= {1'b0, dvs}) begin
                r_t    = r_sh[31:0] - dvs;
                q_t[0] = 1'b1;
            end else begin
                r_t = r_sh[31:0];
            end
        end
    end

    logic        op_signed;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] fix_res;

    assign op_signed = !op_sel[0];

    always_comb begin
        q_fin = ((op_signed && (op_a[31] ^ op_b[31])) ? -quo : quo);
        r_fin = ((op_signed && op_a[31]) ? -rem : rem);
        if (dv_zero) begin
            q_fin = 32'hFFFFFFFF;
            r_fin = op_a;
        end else if (dv_ovf) begin
            q_fin = 32'h80000000;
            r_fin = 32'h0;
        end
    end

    assign fix_res = op_sel[1] ? r_fin : q_fin;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            op_sel           <= 2'b00;
            op_rd            <= 5'd0;
            op_a             <= 32'h0;
            op_b             <= 32'h0;
            dvs              <= 32'h0;
            rem              <= 32'h0;
            quo              <= 32'h0;
            cnt              <= 6'd0;
            dv_zero          <= 1'b0;
            dv_ovf           <= 1'b0;
            Result           <= 32'h0;
            Out_WriteAddress <= 5'd0;
        end else if (accept) begin
            op_sel  <= func3[1:0];
            op_rd   <= WriteAddress;
            op_a    <= Operand1;
            op_b    <= Operand2;
            dvs     <= in_divisor;
            quo     <= in_dividend;
            rem     <= 32'h0;
            cnt     <= 6'd0;
            dv_zero <= in_zero;
            dv_ovf  <= in_ovf;
        end else if (!Flush) begin
            case (state)
                S_MUL: begin
                    Result           <= mul_res;
                    Out_WriteAddress <= op_rd;
                end
                S_DIV: begin
                    rem <= r_t;
                    quo <= q_t;
                    cnt <= cnt + 6'd1;
                end
                S_FIX: begin
                    Result           <= fix_res;
                    Out_WriteAddress <= op_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed results and latencies.
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic        Flush;
    logic [2:0]  func3;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [4:0]  WriteAddress;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  Out_WriteAddress;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          stl;
    } vec_t;

    ex_muldiv_unit #(.DIV_BITS(1)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .Start            (Start),
        .Flush            (Flush),
        .func3            (func3),
        .Operand1         (Operand1),
        .Operand2         (Operand2),
        .WriteAddress     (WriteAddress),
        .Stall            (Stall),
        .Busy             (Busy),
        .Done             (Done),
        .Result           (Result),
        .Out_WriteAddress (Out_WriteAddress)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issues one op, then returns at #1 after the edge that raised Done.
    // lat counts edges with the accept edge as 1; stl counts Stall-high cycles
    // after the accept edge; lat stays 0 if Done never arrives.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res,
                         output logic [4:0] wa, output int lat, output int stl);
        @(negedge CLK);
        func3 = f; Operand1 = a; Operand2 = b; WriteAddress = rd; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        lat = 0;
        stl = 0;
        for (int e = 1; e <= 100; e++) begin
            if (Done) begin
                lat = e;
                break;
            end
            if (Stall) stl++;
            @(posedge CLK);
            #1;
        end
        res = Result;
        wa  = Out_WriteAddress;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #2;
        n_cmp += 5;
        if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", Stall); end
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
        if (Result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", Result); end
        if (Out_WriteAddress !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", Out_WriteAddress); end
        repeat (2) @(posedge CLK);
        @(negedge CLK) Reset = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        n_cmp += 2;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", Busy); end
        if (Done !== 1'b0) begin n_bad++; $display("FAIL idle_done: got %b want 0", Done); end
    endtask

    task automatic test_mul();
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd11, res, wa, lat, stl);
        n_cmp += 5;
        if (res !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        if (lat !== 2) begin n_bad++; $display("FAIL mul_latency: got %0d want 2", lat); end
        if (stl !== 1) begin n_bad++; $display("FAIL mul_stall_cycles: got %0d want 1", stl); end
        if (wa !== 5'd11) begin n_bad++; $display("FAIL mul_rd: got %0d want 11", wa); end
        if (Stall !== 1'b0) begin n_bad++; $display("FAIL mul_stall_in_done: got %b want 0", Stall); end
        @(posedge CLK);
        #1;
        n_cmp += 2;
        if (Done !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse: got %b want 0", Done); end
        if (Result !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result_hold: got %h want ffffffeb", Result); end
    endtask

    task automatic test_mul_high();
        vec_t v [3];
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        v[0] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1};
        v[1] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2, 1};
        v[2] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 1};
        for (int i = 0; i < 3; i++) begin
            do_op(v[i].f, v[i].a, v[i].b, 5'(i + 1), res, wa, lat, stl);
            n_cmp += 2;
            if (res !== v[i].exp) begin n_bad++; $display("FAIL mulh_result[%0d]: got %h want %h", i, res, v[i].exp); end
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL mulh_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_div();
        vec_t v [4];
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        v[0] = '{3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34, 33};
        v[1] = '{3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34, 33};
        v[2] = '{3'b101, 32'd100, 32'd7, 32'd14, 34, 33};
        v[3] = '{3'b111, 32'd100, 32'd7, 32'd2, 34, 33};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].f, v[i].a, v[i].b, 5'd5, res, wa, lat, stl);
            n_cmp += 4;
            if (res !== v[i].exp) begin n_bad++; $display("FAIL div_result[%0d]: got %h want %h", i, res, v[i].exp); end
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
            if (stl !== v[i].stl) begin n_bad++; $display("FAIL div_stall_cycles[%0d]: got %0d want %0d", i, stl, v[i].stl); end
            if (wa !== 5'd5) begin n_bad++; $display("FAIL div_rd[%0d]: got %0d want 5", i, wa); end
        end
    endtask

    task automatic test_div_special();
        vec_t v [4];
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        v[0] = '{3'b101, 32'd100, 32'd0, 32'hFFFFFFFF, 2, 1};
        v[1] = '{3'b110, 32'd100, 32'd0, 32'd100, 2, 1};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].f, v[i].a, v[i].b, 5'd20, res, wa, lat, stl);
            n_cmp += 3;
            if (res !== v[i].exp) begin n_bad++; $display("FAIL special_result[%0d]: got %h want %h", i, res, v[i].exp); end
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL special_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
            if (stl !== v[i].stl) begin n_bad++; $display("FAIL special_stall_cycles[%0d]: got %0d want %0d", i, stl, v[i].stl); end
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        int done_seen;
        do_op(3'b000, 32'd3, 32'd4, 5'd9, res, wa, lat, stl);
        n_cmp += 1;
        if (res !== 32'd12) begin n_bad++; $display("FAIL flush_setup_result: got %h want c", res); end
        @(negedge CLK);
        func3 = 3'b100; Operand1 = 32'd1000; Operand2 = 32'd7; WriteAddress = 5'd3; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1 Flush = 1'b1;
        @(posedge CLK);
        #1 Flush = 1'b0;
        n_cmp += 5;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", Busy); end
        if (Stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", Stall); end
        if (Done !== 1'b0) begin n_bad++; $display("FAIL flush_done: got %b want 0", Done); end
        if (Result !== 32'd12) begin n_bad++; $display("FAIL flush_result_kept: got %h want c", Result); end
        if (Out_WriteAddress !== 5'd9) begin n_bad++; $display("FAIL flush_rd_kept: got %0d want 9", Out_WriteAddress); end
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (Done) done_seen++;
        end
        n_cmp += 1;
        if (done_seen !== 0) begin n_bad++; $display("FAIL flush_no_done: got %0d pulses want 0", done_seen); end

        @(negedge CLK);
        func3 = 3'b101; Operand1 = 32'd5000; Operand2 = 32'd9; WriteAddress = 5'd4; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        n_cmp += 1;
        if (Busy !== 1'b1) begin n_bad++; $display("FAIL reset_mid_busy_before: got %b want 1", Busy); end
        #1 Reset = 1'b0;
        #1;
        n_cmp += 5;
        if (Stall !== 1'b0) begin n_bad++; $display("FAIL midreset_stall: got %b want 0", Stall); end
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", Busy); end
        if (Done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b want 0", Done); end
        if (Result !== 32'h0) begin n_bad++; $display("FAIL midreset_result: got %h want 0", Result); end
        if (Out_WriteAddress !== 5'd0) begin n_bad++; $display("FAIL midreset_rd: got %0d want 0", Out_WriteAddress); end
        @(negedge CLK) Reset = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic [4:0] wa; int lat, stl;
        do_op(3'b000, 32'd6, 32'd7, 5'd1, res, wa, lat, stl);
        n_cmp += 2;
        if (res !== 32'd42) begin n_bad++; $display("FAIL b2b_first_result: got %h want 2a", res); end
        if (lat !== 2) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 2", lat); end
        func3 = 3'b000; Operand1 = 32'd5; Operand2 = 32'd5; WriteAddress = 5'd2; Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        n_cmp += 2;
        if (Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b want 1", Busy); end
        if (Done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_done: got %b want 0", Done); end
        @(posedge CLK);
        #1;
        n_cmp += 3;
        if (Done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b want 1", Done); end
        if (Result !== 32'd25) begin n_bad++; $display("FAIL b2b_second_result: got %h want 19", Result); end
        if (Out_WriteAddress !== 5'd2) begin n_bad++; $display("FAIL b2b_second_rd: got %0d want 2", Out_WriteAddress); end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; func3 = 3'b000;
        Operand1 = 32'h0; Operand2 = 32'h0; WriteAddress = 5'd0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_div_special();
        test_flush_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
